// File: rtl/decode_stage.sv
// decode_stage
// Registered, handshaked RV32I/RV64I decode stage between fetch and register read.
// Each accepted instruction is classified, its register fields are extracted, an
// XLEN-wide sign-extended immediate is built and illegal encodings are flagged. A
// main register drives the outputs and a skid register absorbs one extra transfer, so
// fetch keeps full throughput under back-pressure.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   flush                    drop both buffered entries; input offered this cycle is dropped
//   in_valid/in_ready        upstream handshake; in_ready = skid register empty
//   in_instruction, in_pc    raw 32-bit instruction and its XLEN-wide address
//   out_valid/out_ready      downstream handshake
//   out_pc, out_class        PC and one-hot class of the entry in the main register
//   out_immediate            sign-extended immediate (0 for R-type and illegal entries)
//   out_rs1/rs2/rd(+_valid)  register indices and whether each is used
//   out_funct3, out_funct7   raw function fields
//   out_illegal              entry is an illegal encoding
//   illegal_count            saturating count of illegal entries delivered downstream
module decode_stage #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CHECK_FUNCT = 1,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instruction,
   input  logic [XLEN-1:0]      in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [9:0]           out_class,
   output logic [XLEN-1:0]      out_immediate,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [4:0]           out_rd,
   output logic                 out_rs1_valid,
   output logic                 out_rs2_valid,
   output logic                 out_rd_valid,
   output logic [2:0]           out_funct3,
   output logic [6:0]           out_funct7,
   output logic                 out_illegal,
   output logic [CNT_WIDTH-1:0] illegal_count
);

   localparam bit Is64 = (XLEN == 64);

   localparam logic [6:0] OpcReg    = 7'b0110011;
   localparam logic [6:0] OpcImm    = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [9:0]      cls;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rs1_valid;
      logic            rs2_valid;
      logic            rd_valid;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            illegal;
   } entry_t;

   // Widen a 32-bit sign-extended value to XLEN (no-op at XLEN=32).
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // ---------------------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ---------------------------------------------------------------------------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd_idx;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        sh_zero, sh_sra;
   logic [9:0]  cls;
   fmt_e        fmt;
   logic        known;
   logic        funct_bad;
   logic        illegal;
   entry_t      dec;

   assign opcode = in_instruction[6:0];
   assign funct3 = in_instruction[14:12];
   assign funct7 = in_instruction[31:25];
   assign rd_idx = in_instruction[11:7];

   assign imm_i = {{20{in_instruction[31]}}, in_instruction[31:20]};
   assign imm_s = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
   assign imm_b = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                   in_instruction[30:25], in_instruction[11:8], 1'b0};
   assign imm_u = {in_instruction[31:12], 12'b0};
   assign imm_j = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                   in_instruction[20], in_instruction[30:21], 1'b0};

   // Shift-immediate upper field: RV64 uses a 6-bit shamt, so the field shrinks by one bit.
   assign sh_zero = Is64 ? (in_instruction[31:26] == 6'b000000)
                         : (in_instruction[31:25] == 7'b0000000);
   assign sh_sra  = Is64 ? (in_instruction[31:26] == 6'b010000)
                         : (in_instruction[31:25] == 7'b0100000);

   always_comb begin
      cls       = '0;
      fmt       = FmtR;
      known     = 1'b1;
      funct_bad = 1'b0;
      case (opcode)
         OpcReg: begin
            cls[0]    = 1'b1;
            fmt       = FmtR;
            funct_bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000) ||
                        (funct7 == 7'b0100000 && !(funct3 == 3'b000 || funct3 == 3'b101));
         end
         OpcImm: begin
            cls[1] = 1'b1;
            fmt    = FmtI;
            if (funct3 == 3'b001) funct_bad = !sh_zero;
            if (funct3 == 3'b101) funct_bad = !(sh_zero || sh_sra);
         end
         OpcLoad: begin
            cls[2]    = 1'b1;
            fmt       = FmtI;
            funct_bad = (funct3 == 3'b111) ||
                        (!Is64 && (funct3 == 3'b011 || funct3 == 3'b110));
         end
         OpcStore: begin
            cls[3]    = 1'b1;
            fmt       = FmtS;
            funct_bad = funct3[2] || (!Is64 && funct3 == 3'b011);
         end
         OpcBranch: begin
            cls[4]    = 1'b1;
            fmt       = FmtB;
            funct_bad = (funct3[2:1] == 2'b01);
         end
         OpcJal: begin
            cls[5] = 1'b1;
            fmt    = FmtJ;
         end
         OpcJalr: begin
            cls[6]    = 1'b1;
            fmt       = FmtI;
            funct_bad = (funct3 != 3'b000);
         end
         OpcLui: begin
            cls[7] = 1'b1;
            fmt    = FmtU;
         end
         OpcAuipc: begin
            cls[8] = 1'b1;
            fmt    = FmtU;
         end
         OpcSystem: begin
            cls[9]    = 1'b1;
            fmt       = FmtI;
            funct_bad = (funct3 == 3'b100);
         end
         default: known = 1'b0;
      endcase
   end

   assign illegal = !known || (opcode[1:0] != 2'b11) || ((CHECK_FUNCT != 0) && funct_bad);

   always_comb begin
      dec           = '0;
      dec.pc        = in_pc;
      dec.rs1       = in_instruction[19:15];
      dec.rs2       = in_instruction[24:20];
      dec.rd        = rd_idx;
      dec.funct3    = funct3;
      dec.funct7    = funct7;
      dec.illegal   = illegal;
      // Illegal entries keep raw fields and PC but carry no class, immediate or valids.
      if (!illegal) begin
         dec.cls       = cls;
         dec.rs1_valid = (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtS) || (fmt == FmtB);
         dec.rs2_valid = (fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB);
         dec.rd_valid  = ((fmt == FmtR) || (fmt == FmtI) || (fmt == FmtU) || (fmt == FmtJ)) &&
                         (rd_idx != 5'd0);
         case (fmt)
            FmtI:    dec.imm = sext32(imm_i);
            FmtS:    dec.imm = sext32(imm_s);
            FmtB:    dec.imm = sext32(imm_b);
            FmtU:    dec.imm = sext32(imm_u);
            FmtJ:    dec.imm = sext32(imm_j);
            default: dec.imm = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------
   // Two-entry buffer: main drives the outputs, skid catches the transfer that arrives
   // while main is stalled.
   // ---------------------------------------------------------------------------------
   entry_t                main_q, main_d;
   entry_t                skid_q, skid_d;
   logic                  main_valid_q, main_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  in_fire, out_fire, main_free;

   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign in_fire   = in_valid && in_ready && !flush;
   assign out_fire  = main_valid_q && out_ready;
   assign main_free = !main_valid_q || out_fire;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // Older skid entry advances; a new arrival refills the skid to keep order.
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = in_fire;
            if (in_fire) skid_d = dec;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) main_d = dec;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   // Delivery in a flush cycle still counts: out_fire does not look at flush.
   always_comb begin
      cnt_d = cnt_q;
      if (out_fire && main_q.illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_pc        = main_q.pc;
   assign out_class     = main_q.cls;
   assign out_immediate = main_q.imm;
   assign out_rs1       = main_q.rs1;
   assign out_rs2       = main_q.rs2;
   assign out_rd        = main_q.rd;
   assign out_rs1_valid = main_q.rs1_valid;
   assign out_rs2_valid = main_q.rs2_valid;
   assign out_rd_valid  = main_q.rd_valid;
   assign out_funct3    = main_q.funct3;
   assign out_funct7    = main_q.funct7;
   assign out_illegal   = main_q.illegal;
   assign illegal_count = cnt_q;

endmodule
